shifter_2d_drain: RTL and testbench

Parallel-load, serial-unload word bank: the write-side counterpart of the tapped serial delay line in the FIFO data path. Upstream logic writes `size`-bit words into any of `tamanyo` slots by index; on `start` the bank drains a programmable number of words, slot 0 first, through a valid/ready serial port. It feeds serial word streams into the shifter/FIFO data path from random-access sources.

---
 rtl/shifter_2d_drain.sv | 92 +++++++++
 tb/tb_shifter_2d_drain.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/shifter_2d_drain.sv
// Parallel-load, serial-unload word bank: random-access writes while idle, then a
// valid/ready drain of a programmable number of words starting at slot 0.
module shifter_2d_drain #(
  parameter int unsigned tamanyo = 32,
  parameter int unsigned size    = 8,
  localparam int unsigned SelW   = $clog2(tamanyo),
  localparam int unsigned CntW   = $clog2(tamanyo + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [SelW-1:0] wr_sel,
  input  logic [size-1:0] wr_data,
  input  logic            start,
  input  logic [CntW-1:0] longitud,
  input  logic            ready_in,
  output logic [size-1:0] salida_serie,
  output logic            salida_valida,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [size-1:0] bank_q [tamanyo];
  logic [size-1:0] bank_d [tamanyo];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    unique case (state_q)
      StIdle: begin
        // Write lands on the same edge as start, so the drain sees it.
        if (wr_en && (32'(wr_sel) < tamanyo)) begin
          bank_d[wr_sel] = wr_data;
        end
        if (start && (longitud != '0)) begin
          state_d = StDrain;
          cnt_d   = (longitud > CntW'(tamanyo)) ? CntW'(tamanyo) : longitud;
        end
      end
      StDrain: begin
        if (ready_in) begin
          for (int unsigned i = 0; i < tamanyo - 1; i++) begin
            bank_d[i] = bank_q[i+1];
          end
          bank_d[tamanyo-1] = '0;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Synchronous clear beats every other input.
    if (!clear) begin
      state_d = StIdle;
      cnt_d   = '0;
      for (int unsigned i = 0; i < tamanyo; i++) begin
        bank_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < tamanyo; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int unsigned i = 0; i < tamanyo; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign salida_serie  = bank_q[0];
  assign salida_valida = (state_q == StDrain);
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_shifter_2d_drain.sv
// Randomized bench for shifter_2d_drain against an array model of the word bank.
module tb_shifter_2d_drain;
  localparam int T = 32;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset, clear, wr_en, start, ready_in;
  logic [4:0]   wr_sel;
  logic [W-1:0] wr_data, salida_serie;
  logic [5:0]   longitud;
  logic         salida_valida, busy, done;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mdl [T];

  always #5 clock = ~clock;

  shifter_2d_drain #(.tamanyo(T), .size(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .start        (start),
    .longitud     (longitud),
    .ready_in     (ready_in),
    .salida_serie (salida_serie),
    .salida_valida(salida_valida),
    .busy         (busy),
    .done         (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < T; i++) mdl[i] = '0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_serie"}, 32'(salida_serie), 32'(mdl[0]));
    check_eq({tag, "_valid"}, 32'(salida_valida), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic wr(input int sel, input logic [W-1:0] d);
    wr_en = 1'b1; wr_sel = 5'(sel); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (sel < T) mdl[sel] = d;
  endtask

  // mode 0: ready high; 1: random ready plus ignored start/wr_en noise; 2: ready low 2 cycles
  task automatic drain(input int len, input int mode, input bit wr_with, input int wsel,
                       input logic [W-1:0] wdat);
    int n, k, cyc;
    bit rdy;
    logic [W-1:0] exp_q[$];
    start = 1'b1; longitud = 6'(len);
    if (wr_with) begin
      wr_en = 1'b1; wr_sel = 5'(wsel); wr_data = wdat;
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    if (wr_with && wsel < T) mdl[wsel] = wdat;
    n = (len > T) ? T : len;
    if (n == 0) begin
      check_idle("len0");
      return;
    end
    for (int i = 0; i < n; i++) exp_q.push_back(mdl[i]);
    k = 0; cyc = 0;
    while (k < n && cyc < 400) begin
      case (mode)
        1:       rdy = ($urandom_range(0, 3) != 0);
        2:       rdy = (cyc >= 2);
        default: rdy = 1'b1;
      endcase
      ready_in = rdy;
      if (mode == 1) begin
        start = 1'($urandom_range(0, 1)); longitud = 6'($urandom_range(1, 33));
        wr_en = 1'($urandom_range(0, 1)); wr_sel = 5'($urandom); wr_data = 8'($urandom);
      end
      check_eq("drain_valid", 32'(salida_valida), 1);
      check_eq("drain_word", 32'(salida_serie), 32'(exp_q[k]));
      check_eq("drain_busy", 32'(busy), 1);
      check_eq("drain_done", 32'(done), 0);
      tick();
      if (rdy) k++;
      cyc++;
    end
    start = 1'b0; wr_en = 1'b0; ready_in = 1'b1;
    if (k < n) check_eq("drain_timeout", k, n);
    if (mode == 0) check_eq("valid_cycles", cyc, n);
    for (int i = 0; i < T; i++) mdl[i] = (i + n < T) ? mdl[i+n] : '0;
    check_eq("done_pulse", 32'(done), 1);
    check_eq("done_valid", 32'(salida_valida), 0);
    check_eq("done_busy", 32'(busy), 1);
    check_eq("done_residue", 32'(salida_serie), 32'(mdl[0]));
    tick();
    check_idle("after_done");
  endtask

  task automatic abort(input bit use_reset);
    start = 1'b1; longitud = 6'd8; ready_in = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("abort_valid_before", 32'(salida_valida), 1);
    if (use_reset) begin
      #2 reset = 1'b0;
      #1;
      model_clear();
      check_idle("async_reset");
      #2 reset = 1'b1;
    end else begin
      clear = 1'b0;
      tick();
      clear = 1'b1;
      model_clear();
      check_idle("sync_clear");
    end
    tick();
    check_idle("after_abort");
  endtask

  initial begin
    reset = 1'b0; clear = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    start = 1'b0; longitud = '0; ready_in = 1'b1;
    model_clear();
    #12;
    check_idle("in_reset");
    reset = 1'b1;
    tick();
    check_idle("post_reset");

    // Reset wipes previously written slots.
    for (int i = 0; i < 4; i++) wr(i, 8'(8'h11 * (i + 1)));
    check_eq("slot0_written", 32'(salida_serie), 32'h11);
    #2 reset = 1'b0;
    #1;
    model_clear();
    check_idle("reset_wipe");
    #2 reset = 1'b1;
    tick();
    drain(4, 0, 0, 0, '0);

    for (int i = 0; i < T; i++) wr(i, 8'(i + 1));
    drain(32, 0, 0, 0, '0);

    wr(0, 8'hA1); wr(1, 8'hB2); wr(2, 8'hC3);
    drain(3, 2, 0, 0, '0);

    drain(0, 0, 0, 0, '0);
    for (int i = 0; i < T; i++) wr(i, 8'($urandom));
    drain(33, 0, 0, 0, '0);
    wr(31, 8'h77);
    drain(32, 0, 0, 0, '0);

    drain(1, 0, 1, 0, 8'h5A);
    for (int i = 0; i < 8; i++) wr(i, 8'($urandom));
    drain(3, 1, 0, 0, '0);
    drain(5, 0, 0, 0, '0);

    for (int i = 0; i < 4; i++) wr(i, 8'(i + 1));
    drain(2, 0, 0, 0, '0);
    drain(2, 0, 0, 0, '0);

    for (int i = 0; i < 4; i++) wr(i, 8'($urandom_range(1, 255)));
    abort(1'b1);
    for (int i = 0; i < 4; i++) wr(i, 8'($urandom_range(1, 255)));
    abort(1'b0);

    for (int r = 0; r < 30; r++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int j = 0; j < nw; j++) wr($urandom_range(0, 31), 8'($urandom));
      drain($urandom_range(0, 33), $urandom_range(0, 1), 1'($urandom_range(0, 1)),
            $urandom_range(0, 31), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
